fetch_queue_unit: RTL and testbench

//  Parametrised instruction-fetch front end for the next-generation core: owns the PC, issues

---
 rtl/fetch_queue_unit_pkg.sv | 17 +
 rtl/sync_fifo.sv | 83 ++++++++
 rtl/fetch_queue_unit.sv | 118 +++++++++++
 tb/tb_fetch_queue_unit.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_unit_pkg.sv
// rtl/fetch_queue_unit_pkg.sv - shared constants and helpers for the fetch front end
//
// Purpose : Instruction width, default reset PC and the PC alignment check
//           used by fetch_queue_unit and its sub-modules.
// Ports   : none (package).

package fetch_queue_unit_pkg;

   localparam int          INSTR_W          = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // Instructions are 32-bit and word aligned; any set low bit is a bad target.
   function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
      return pc_lsb != 2'b00;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with flush, occupancy count and zeroed-when-empty head
//
// Purpose : Generic DEPTH-entry queue (any DEPTH >= 2, not only powers of two).
//           Head data comes straight from the storage registers, so there is
//           no combinational path from push_data to head_data (no bypass).
// Ports   : clk        - clock
//           rst        - synchronous active-high reset
//           flush      - synchronous empty; wins over push/pop
//           push       - write push_data at the tail (ignored when full without pop)
//           push_data  - entry to write
//           pop        - discard head (ignored when empty)
//           head_valid - queue not empty
//           head_data  - oldest entry, all-zero when empty
//           count      - entries currently held

module sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic                       head_valid,
   output logic [WIDTH-1:0]           head_data,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int              PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int              CW       = $clog2(DEPTH + 1);
   localparam logic [PW-1:0]   LAST_IDX = PW'(DEPTH - 1);
   localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0]   ONE_CNT  = CW'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [CW-1:0]    cnt;
   logic             empty;
   logic             full;
   logic             do_pop;
   logic             do_push;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_IDX) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (cnt == '0);
   assign full    = (cnt == FULL_CNT);
   assign do_pop  = pop & ~empty;
   // A push into a full queue is legal only when the head leaves in the same cycle.
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + ONE_CNT;
            2'b01:   cnt <= cnt - ONE_CNT;
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage carries no reset; emptiness is tracked by cnt alone.
   always_ff @(posedge clk) begin
      if (do_push && !flush && !rst) begin
         mem[wr_ptr] <= push_data;
      end
   end

   assign head_valid = ~empty;
   assign head_data  = empty ? '0 : mem[rd_ptr];
   assign count      = cnt;

endmodule

// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - instruction fetch front end with PC, credit-based issue and fetch queue
//
// Purpose : Owns the fetch PC, issues reads to a 1-cycle synchronous
//           instruction memory and queues {pc, instr} pairs for decode.
//           Handles redirect with flush, halt, and misaligned redirect targets.
// Ports   : clk            - clock
//           rst            - synchronous active-high reset
//           imem_req       - read request this cycle
//           imem_addr      - word address of the request (fpc[IMEM_AW+1:2])
//           imem_rdata     - instruction, valid the cycle after imem_req
//           out_valid      - queue head valid
//           out_ready      - decode accepts the head
//           out_instr      - head instruction (0 when empty)
//           out_pc         - head PC (0 when empty)
//           redirect_valid - flush queue and restart fetch at redirect_pc
//           redirect_pc    - new fetch PC
//           halt           - level; blocks new requests
//           misalign_err   - sticky until rst: a redirect target was not word aligned
//           occupancy      - entries currently queued

module fetch_queue_unit
   import fetch_queue_unit_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter int              IMEM_AW  = 7,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
   input  logic                       clk,
   input  logic                       rst,
   output logic                       imem_req,
   output logic [IMEM_AW-1:0]         imem_addr,
   input  logic [INSTR_W-1:0]         imem_rdata,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [INSTR_W-1:0]         out_instr,
   output logic [XLEN-1:0]            out_pc,
   input  logic                       redirect_valid,
   input  logic [XLEN-1:0]            redirect_pc,
   input  logic                       halt,
   output logic                       misalign_err,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);

   localparam int              CW        = $clog2(DEPTH + 1);
   localparam int              EW        = XLEN + INSTR_W;
   localparam logic [CW:0]     DEPTH_LIM = DEPTH[CW:0];
   localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);

   logic [XLEN-1:0] fpc;
   logic [XLEN-1:0] req_pc;
   logic            inflight;
   logic            misalign_q;
   logic            pop;
   logic            push;
   logic            issue;
   logic [CW:0]     credit_used;
   logic            head_valid;
   logic [EW-1:0]   head_data;
   logic [CW-1:0]   count;

   // Slots already spoken for: queued entries plus the response in flight,
   // minus the head leaving this cycle. One spare bit keeps DEPTH+1 representable.
   assign pop         = head_valid & out_ready;
   assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};

   assign issue = ~rst & ~halt & ~misalign_q & ~redirect_valid & (credit_used < DEPTH_LIM);

   // A response returning in a redirect cycle belongs to the old path. A
   // redirect or reset one cycle earlier already blocked the request, and
   // reset clears inflight, so this is the only kill case left.
   assign push = inflight & ~redirect_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         fpc        <= RESET_PC;
         req_pc     <= RESET_PC;
         inflight   <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         inflight <= issue;
         if (redirect_valid) begin
            // The bad target is still loaded so it can be inspected after the error.
            fpc <= redirect_pc;
            if (pc_misaligned(redirect_pc[1:0])) begin
               misalign_q <= 1'b1;
            end
         end else if (issue) begin
            req_pc <= fpc;
            fpc    <= fpc + PC_STEP;
         end
      end
   end

   sync_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk        (clk),
      .rst        (rst),
      .flush      (redirect_valid),
      .push       (push),
      .push_data  ({req_pc, imem_rdata}),
      .pop        (pop),
      .head_valid (head_valid),
      .head_data  (head_data),
      .count      (count)
   );

   assign imem_req     = issue;
   assign imem_addr    = fpc[IMEM_AW+1:2];
   assign out_valid    = head_valid;
   assign out_pc       = head_data[EW-1:INSTR_W];
   assign out_instr    = head_data[INSTR_W-1:0];
   assign misalign_err = misalign_q;
   assign occupancy    = count;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb/tb_fetch_queue_unit.sv - self-checking bench for fetch_queue_unit
//
// Purpose : Directed scenarios plus randomized traffic against a queue-based reference model.
// Ports   : none (top-level bench).

module tb_fetch_queue_unit;

   localparam int DEPTH = 4;
   localparam int AW    = 7;

   logic          clk;
   logic          rst;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_rdata;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_instr;
   logic [31:0]   out_pc;
   logic          redirect_valid;
   logic [31:0]   redirect_pc;
   logic          halt;
   logic          misalign_err;
   logic [2:0]    occupancy;

   int checks = 0;
   int errors = 0;

   // Reference model: fetch PC, one pending request, queue of fetched PCs.
   logic [31:0] m_fpc;
   bit          m_infl;
   logic [31:0] m_infl_pc;
   logic [31:0] m_q[$];
   bit          m_err;

   // Expected outputs for the current cycle.
   bit          e_req;
   bit          e_valid;
   bit          e_err;
   logic [31:0] e_pc;
   logic [31:0] e_instr;
   logic [AW-1:0] e_addr;
   int          e_occ;

   fetch_queue_unit #(
      .XLEN     (32),
      .DEPTH    (DEPTH),
      .IMEM_AW  (AW),
      .RESET_PC (32'h0)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt),
      .misalign_err   (misalign_err),
      .occupancy      (occupancy)
   );

   always #5 clk = ~clk;

   // Instruction memory: mem[i] = i, one cycle read latency.
   always @(posedge clk) begin
      if (imem_req) imem_rdata <= {25'd0, imem_addr};
   end

   // Drive one cycle of inputs at the falling edge, derive the expected outputs
   // from the model, then advance the model to the state after the next rising edge.
   task automatic cyc(input bit r, input bit rv, input logic [31:0] rpc, input bit h, input bit rdy);
      int sz;
      bit pop;
      @(negedge clk);
      rst            = r;
      redirect_valid = rv;
      redirect_pc    = rpc;
      halt           = h;
      out_ready      = rdy;
      sz      = m_q.size();
      pop     = (sz > 0) && rdy;
      e_valid = (sz > 0);
      e_pc    = (sz > 0) ? m_q[0] : 32'h0;
      e_instr = (sz > 0) ? ((m_q[0] >> 2) & 32'h7F) : 32'h0;
      e_occ   = sz;
      e_err   = m_err;
      e_addr  = m_fpc[AW+1:2];
      e_req   = !r && !h && !m_err && !rv && ((sz + int'(m_infl) - int'(pop)) < DEPTH);
      if (r) begin
         m_fpc  = 32'h0;
         m_infl = 0;
         m_err  = 0;
         m_q.delete();
      end else if (rv) begin
         m_q.delete();
         m_infl = 0;
         m_fpc  = rpc;
         if (rpc[1:0] != 2'b00) m_err = 1;
      end else begin
         if (pop) void'(m_q.pop_front());
         if (m_infl) m_q.push_back(m_infl_pc);
         if (e_req) begin
            m_infl_pc = m_fpc;
            m_fpc     = m_fpc + 32'd4;
         end
         m_infl = e_req;
      end
      #1;
   endtask

   task automatic test_reset();
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b want 0", imem_req); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
      checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ got %0d want 0", occupancy); end
      checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", misalign_err); end
      checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %0h want 0", out_pc); end
      checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %0h want 0", out_instr); end
   endtask

   task automatic test_stream();
      for (int k = 0; k < 12; k++) begin
         cyc(0, 0, 0, 0, 1);
         checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL stream_req cyc %0d got %0b want 1", k, imem_req); end
         if (k >= 2) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid cyc %0d got %0b want 1", k, out_valid); end
            checks++; if (out_pc !== 32'(4 * (k - 2))) begin errors++; $display("FAIL stream_pc cyc %0d got %0h want %0h", k, out_pc, 4 * (k - 2)); end
            checks++; if (out_instr !== 32'(k - 2)) begin errors++; $display("FAIL stream_instr cyc %0d got %0h want %0h", k, out_instr, k - 2); end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_next;
      int npop;
      cyc(1, 0, 0, 0, 0);
      for (int k = 0; k < 10; k++) begin
         cyc(0, 0, 0, 0, 0);
         checks++; if (occupancy !== 3'(e_occ)) begin errors++; $display("FAIL bp_occ cyc %0d got %0d want %0d", k, occupancy, e_occ); end
         checks++; if (imem_req !== e_req) begin errors++; $display("FAIL bp_req cyc %0d got %0b want %0b", k, imem_req, e_req); end
      end
      checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL bp_full got %0d want 4", occupancy); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_stall got %0b want 0", imem_req); end
      exp_next = 32'h0;
      npop = 0;
      for (int k = 0; k < 20; k++) begin
         cyc(0, 0, 0, 0, 1);
         if (out_valid && out_ready) begin
            checks++; if (out_pc !== exp_next) begin errors++; $display("FAIL bp_order got %0h want %0h", out_pc, exp_next); end
            exp_next = exp_next + 32'd4;
            npop++;
         end
      end
      checks++; if (npop != 20) begin errors++; $display("FAIL bp_gap got %0d want 20", npop); end
   endtask

   task automatic test_redirect();
      logic [31:0] exp_next;
      int n;
      int npop;
      cyc(1, 0, 0, 0, 0);
      n = 0;
      while (!(m_q.size() == 3 && m_infl) && n < 10) begin
         cyc(0, 0, 0, 0, 0);
         n++;
      end
      checks++; if (n >= 10) begin errors++; $display("FAIL redir_setup got %0d cycles want < 10", n); end
      cyc(0, 1, 32'h100, 0, 1);
      checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL redir_pre_occ got %0d want 3", occupancy); end
      cyc(0, 0, 0, 0, 1);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got %0b want 0", out_valid); end
      checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL redir_occ got %0d want 0", occupancy); end
      exp_next = 32'h100;
      npop = 0;
      for (int k = 0; k < 10; k++) begin
         cyc(0, 0, 0, 0, 1);
         if (out_valid && out_ready) begin
            checks++; if (out_pc !== exp_next) begin errors++; $display("FAIL redir_pc got %0h want %0h", out_pc, exp_next); end
            exp_next = exp_next + 32'd4;
            npop++;
         end
      end
      checks++; if (npop != 9) begin errors++; $display("FAIL redir_count got %0d want 9", npop); end
   endtask

   task automatic test_misalign();
      cyc(1, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 1);
      cyc(0, 1, 32'h102, 0, 1);
      for (int k = 0; k < 5; k++) begin
         cyc(0, 0, 0, 0, 1);
         checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL mis_err cyc %0d got %0b want 1", k, misalign_err); end
         checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL mis_req cyc %0d got %0b want 0", k, imem_req); end
         checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL mis_occ cyc %0d got %0d want 0", k, occupancy); end
      end
      cyc(1, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1);
      checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL mis_clear got %0b want 0", misalign_err); end
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL mis_restart_req got %0b want 1", imem_req); end
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1);
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin errors++; $display("FAIL mis_restart_pc got %0b/%0h want 1/0", out_valid, out_pc); end
   endtask

   task automatic test_halt();
      logic [31:0] exp_next;
      int halt_pops;
      cyc(1, 0, 0, 0, 0);
      exp_next = 32'h0;
      halt_pops = 0;
      for (int k = 0; k < 19; k++) begin
         bit h;
         h = (k >= 6 && k < 11);
         cyc(0, 0, 0, h, 1);
         if (h) begin
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL halt_req cyc %0d got %0b want 0", k, imem_req); end
         end
         if (out_valid && out_ready) begin
            checks++; if (out_pc !== exp_next) begin errors++; $display("FAIL halt_order got %0h want %0h", out_pc, exp_next); end
            exp_next = exp_next + 32'd4;
            if (k >= 7 && k < 11) halt_pops++;
         end
      end
      checks++; if (halt_pops != 1) begin errors++; $display("FAIL halt_inflight got %0d want 1", halt_pops); end
   endtask

   task automatic test_wrap();
      logic [31:0] pcs[2];
      logic [31:0] ins[2];
      int npop;
      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 32'hFFFF_FFFC, 0, 1);
      npop = 0;
      for (int k = 0; k < 8; k++) begin
         cyc(0, 0, 0, 0, 1);
         if (out_valid && out_ready && npop < 2) begin
            pcs[npop] = out_pc;
            ins[npop] = out_instr;
            npop++;
         end
      end
      checks++;
      if (npop < 2) begin
         errors++; $display("FAIL wrap_count got %0d want 2", npop);
      end else begin
         checks++; if (pcs[0] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc0 got %0h want fffffffc", pcs[0]); end
         checks++; if (ins[0] !== 32'h7F) begin errors++; $display("FAIL wrap_instr0 got %0h want 7f", ins[0]); end
         checks++; if (pcs[1] !== 32'h0) begin errors++; $display("FAIL wrap_pc1 got %0h want 0", pcs[1]); end
         checks++; if (ins[1] !== 32'h0) begin errors++; $display("FAIL wrap_instr1 got %0h want 0", ins[1]); end
      end
   endtask

   task automatic test_random();
      bit h;
      cyc(1, 0, 0, 0, 0);
      h = 0;
      for (int k = 0; k < 3000; k++) begin
         bit r;
         bit rv;
         bit rdy;
         logic [31:0] rpc;
         r   = ($urandom_range(0, 149) == 0);
         rv  = ($urandom_range(0, 24) == 0);
         rdy = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 9) == 0) h = !h;
         rpc = 32'($urandom_range(0, 255)) << 2;
         if ($urandom_range(0, 79) == 0) rpc = rpc | 32'($urandom_range(1, 3));
         cyc(r, rv, rpc, h, rdy);
         checks++; if (imem_req !== e_req) begin errors++; $display("FAIL rand_req cyc %0d got %0b want %0b", k, imem_req, e_req); end
         if (e_req) begin
            checks++; if (imem_addr !== e_addr) begin errors++; $display("FAIL rand_addr cyc %0d got %0h want %0h", k, imem_addr, e_addr); end
         end
         checks++; if (out_valid !== e_valid) begin errors++; $display("FAIL rand_valid cyc %0d got %0b want %0b", k, out_valid, e_valid); end
         checks++; if (out_pc !== e_pc) begin errors++; $display("FAIL rand_pc cyc %0d got %0h want %0h", k, out_pc, e_pc); end
         checks++; if (out_instr !== e_instr) begin errors++; $display("FAIL rand_instr cyc %0d got %0h want %0h", k, out_instr, e_instr); end
         checks++; if (occupancy !== 3'(e_occ)) begin errors++; $display("FAIL rand_occ cyc %0d got %0d want %0d", k, occupancy, e_occ); end
         checks++; if (misalign_err !== e_err) begin errors++; $display("FAIL rand_err cyc %0d got %0b want %0b", k, misalign_err, e_err); end
      end
   endtask

   initial begin
      clk            = 1'b0;
      rst            = 1'b1;
      out_ready      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      halt           = 1'b0;
      m_fpc          = 32'h0;
      m_infl         = 0;
      m_infl_pc      = 32'h0;
      m_err          = 0;
      m_q.delete();
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_misalign();
      test_halt();
      test_wrap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
